// File: rtl/mips_fetch_pkg.sv
// mips_fetch_pkg: shared fetch-stage types (FSM states, next-PC select codes) and PC width
package mips_fetch_pkg;
  localparam int PC_W = 32;
  typedef enum logic [1:0] {BOOT, RUN, STALL, HALT} state_e;
  typedef enum logic [1:0] {SEQ, BR, J, JR} sel_e;
endpackage

// File: rtl/pc_fetch_unit_if.sv
// pc_fetch_unit_if: fetch bus (redirect/stall in; address, memread, pc_plus1, fetch_valid, halted out; counters with FETCH_PERF_CNT_EN)
interface pc_fetch_unit_if;
  import mips_fetch_pkg::*;
  logic stall, branch_taken, jump, jump_reg, memread, fetch_valid, halted;
  logic [15:0] branch_offset;
  logic [25:0] jump_target;
  logic [PC_W-1:0] reg_target, address, pc_plus1;
`ifdef FETCH_PERF_CNT_EN
  logic [PC_W-1:0] fetch_count, redirect_count;
`endif
  modport master (
    output stall, branch_taken, branch_offset, jump, jump_target, jump_reg, reg_target,
    input address, memread, pc_plus1, fetch_valid, halted
`ifdef FETCH_PERF_CNT_EN
    , input fetch_count, redirect_count
`endif
  );
  modport slave (
    input stall, branch_taken, branch_offset, jump, jump_target, jump_reg, reg_target,
    output address, memread, pc_plus1, fetch_valid, halted
`ifdef FETCH_PERF_CNT_EN
    , output fetch_count, redirect_count
`endif
  );
endinterface

// File: rtl/next_pc_mux.sv
// next_pc_mux: priority next-PC select (jr > j > branch > seq) with adders; ports pc_i, redirect inputs, pc_plus1_o, next_pc_o, out_of_range_o
module next_pc_mux
  import mips_fetch_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 256
) (
  input  logic [PC_W-1:0] pc_i,
  input  logic            jump_reg_i,
  input  logic            jump_i,
  input  logic            branch_i,
  input  logic [15:0]     branch_offset_i,
  input  logic [25:0]     jump_target_i,
  input  logic [PC_W-1:0] reg_target_i,
  output logic [PC_W-1:0] pc_plus1_o,
  output logic [PC_W-1:0] next_pc_o,
  output logic            out_of_range_o
);
  sel_e sel;
  always_comb begin
    pc_plus1_o = pc_i + PC_W'(1);
    sel = jump_reg_i ? JR : jump_i ? J : branch_i ? BR : SEQ;
    next_pc_o = sel == JR ? reg_target_i :
                sel == J  ? {pc_plus1_o[31:26], jump_target_i} :
                sel == BR ? pc_plus1_o + {{16{branch_offset_i[15]}}, branch_offset_i} :
                            pc_plus1_o;
    out_of_range_o = next_pc_o >= PC_W'(MEM_DEPTH);
  end
endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: word-address PC/next-PC stage with BOOT/RUN/STALL/HALT FSM; ports clk, rst, bus (pc_fetch_unit_if.slave); FETCH_PERF_CNT_EN adds fetch_count/redirect_count
module pc_fetch_unit
  import mips_fetch_pkg::*;
#(
  parameter int unsigned     MEM_DEPTH = 256,
  parameter logic [PC_W-1:0] RESET_PC  = '0
) (
  input logic            clk,
  input logic            rst,
  pc_fetch_unit_if.slave bus
);
  state_e state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, next_pc, pc_plus1;
  logic memread_q, fetch_valid_q, halted_q, oor, run;
  assign run = state_q == RUN;
  // redirects only count in RUN, so STALL exit falls through to the sequential path
  next_pc_mux #(.MEM_DEPTH(MEM_DEPTH)) u_next_pc_mux (
    .pc_i           (pc_q),
    .jump_reg_i     (run & bus.jump_reg),
    .jump_i         (run & bus.jump),
    .branch_i       (run & bus.branch_taken),
    .branch_offset_i(bus.branch_offset),
    .jump_target_i  (bus.jump_target),
    .reg_target_i   (bus.reg_target),
    .pc_plus1_o     (pc_plus1),
    .next_pc_o      (next_pc),
    .out_of_range_o (oor)
  );
  always_comb begin
    state_d = state_q == BOOT ? RUN : state_q == HALT ? HALT : bus.stall ? STALL : oor ? HALT : RUN;
    pc_d = (state_q != BOOT && state_d == RUN) ? next_pc : pc_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      memread_q     <= 1'b0;
      fetch_valid_q <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      memread_q     <= state_d == RUN || state_d == STALL;
      fetch_valid_q <= state_d == RUN;
      halted_q      <= state_d == HALT;
    end
  end
  assign bus.address     = pc_q;
  assign bus.pc_plus1    = pc_plus1;
  assign bus.memread     = memread_q;
  assign bus.fetch_valid = fetch_valid_q;
  assign bus.halted      = halted_q;
`ifdef FETCH_PERF_CNT_EN
  logic [PC_W-1:0] fetch_cnt_q, redirect_cnt_q;
  logic redirect;
  assign redirect = run & ~bus.stall & (bus.jump_reg | bus.jump | bus.branch_taken);
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q    <= '0;
      redirect_cnt_q <= '0;
    end else begin
      if (run && ~&fetch_cnt_q) fetch_cnt_q <= fetch_cnt_q + PC_W'(1);
      if (redirect && ~&redirect_cnt_q) redirect_cnt_q <= redirect_cnt_q + PC_W'(1);
    end
  end
  assign bus.fetch_count    = fetch_cnt_q;
  assign bus.redirect_count = redirect_cnt_q;
`endif
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed and random stimulus against a behavioural fetch model
module tb_pc_fetch_unit;
  localparam int unsigned DEPTH = 256;
  logic clk = 1'b0;
  logic rst;
  int unsigned compared = 0, mismatched = 0;
  logic [31:0] m_pc;
  bit m_boot, m_stall, m_halt;
  int unsigned m_fc, m_rc;
  pc_fetch_unit_if bus();
  pc_fetch_unit #(.MEM_DEPTH(DEPTH), .RESET_PC(32'd0)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic [31:0] t;
    if (rst) begin
      m_pc = 0; m_boot = 1; m_stall = 0; m_halt = 0; m_fc = 0; m_rc = 0;
    end else if (m_boot) begin
      m_boot = 0;
    end else if (!m_halt) begin
      if (!m_stall) m_fc++;
      if (bus.stall) begin
        m_stall = 1;
      end else begin
        t = m_pc + 1;
        if (!m_stall && (bus.jump_reg || bus.jump || bus.branch_taken)) begin
          m_rc++;
          if (bus.jump_reg) t = bus.reg_target;
          else if (bus.jump) t = (t & 32'hFC00_0000) | 32'(bus.jump_target);
          else t = t + 32'($signed(bus.branch_offset));
        end
        m_stall = 0;
        if (t >= DEPTH) m_halt = 1;
        else m_pc = t;
      end
    end
  endtask

  task automatic check_all();
    check("address", bus.address, m_pc);
    check("pc_plus1", bus.pc_plus1, m_pc + 1);
    check("memread", bus.memread, !m_boot && !m_halt);
    check("fetch_valid", bus.fetch_valid, !m_boot && !m_halt && !m_stall);
    check("halted", bus.halted, m_halt);
`ifdef FETCH_PERF_CNT_EN
    check("fetch_count", bus.fetch_count, m_fc);
    check("redirect_count", bus.redirect_count, m_rc);
`endif
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_edge();
    check_all();
  endtask

  task automatic set_in(input bit s, input bit jr, input bit j, input bit br,
                        input logic [31:0] rt, input logic [25:0] jt, input logic [15:0] off);
    bus.stall = s; bus.jump_reg = jr; bus.jump = j; bus.branch_taken = br;
    bus.reg_target = rt; bus.jump_target = jt; bus.branch_offset = off;
  endtask

  initial begin
    rst = 1;
    set_in(0, 0, 0, 0, 0, 0, 0);
    step();
    check("rst_addr", bus.address, 0);
    check("rst_memread", bus.memread, 0);
    rst = 0;
    step();
    check("boot_exit_addr", bus.address, 0);
    check("boot_exit_fv", bus.fetch_valid, 1);
    repeat (3) step();
    check("seq_addr3", bus.address, 3);
    set_in(0, 0, 1, 0, 0, 46, 0); step();
    set_in(0, 0, 0, 1, 0, 0, 16'h0039); step();
    check("branch_fwd", bus.address, 104);
    set_in(0, 0, 1, 0, 0, 10, 0); step();
    set_in(0, 0, 0, 1, 0, 0, 16'hFFFF); repeat (2) step();
    check("self_loop", bus.address, 10);
    check("self_loop_fv", bus.fetch_valid, 1);
    set_in(0, 0, 1, 0, 0, 56, 0); step();
    set_in(0, 0, 1, 0, 0, 26'h2C, 0); step();
    check("jump", bus.address, 44);
    set_in(0, 1, 1, 0, 7, 26'h2C, 0); step();
    check("jr_over_j", bus.address, 7);
    set_in(0, 0, 1, 0, 0, 20, 0); step();
    set_in(1, 0, 1, 0, 0, 99, 0);
    repeat (3) begin
      step();
      check("stall_addr", bus.address, 20);
      check("stall_fv", bus.fetch_valid, 0);
    end
    set_in(0, 0, 0, 0, 0, 0, 0); step();
    check("stall_exit", bus.address, 21);
    set_in(0, 0, 1, 0, 0, 250, 0); step();
    set_in(0, 0, 0, 0, 0, 0, 0); repeat (5) step();
    check("last_pc", bus.address, 255);
    step();
    check("halt_flag", bus.halted, 1);
    check("halt_memread", bus.memread, 0);
    repeat (2) step();
    check("halt_frozen", bus.address, 255);
    rst = 1; step();
    check("rst_from_halt", bus.address, 0);
    check("rst_clears_halt", bus.halted, 0);
    rst = 0; step();
    set_in(0, 1, 0, 0, 32'h100, 0, 0); step();
    check("jr_oob_halt", bus.halted, 1);
    check("jr_oob_addr", bus.address, 0);
    rst = 1; step(); rst = 0; step();
    set_in(0, 0, 0, 1, 0, 0, 16'hFFFE); step();
    check("wrap_halt", bus.halted, 1);
`ifdef FETCH_PERF_CNT_EN
    set_in(0, 0, 0, 0, 0, 0, 0);
    rst = 1; step();
    check("fc_clear", bus.fetch_count, 0);
    check("rc_clear", bus.redirect_count, 0);
    rst = 0; step();
    repeat (5) step();
    set_in(0, 0, 1, 0, 0, 40, 0); step();
    set_in(0, 0, 0, 0, 0, 0, 0); repeat (5) step();
    set_in(0, 0, 0, 1, 0, 0, 16'h0002); step();
    check("fc_12", bus.fetch_count, 12);
    check("rc_2", bus.redirect_count, 2);
`endif
    rst = 1;
    set_in(0, 0, 0, 0, 0, 0, 0);
    step();
    for (int i = 0; i < 600; i++) begin
      int o;
      o = int'($urandom_range(0, 40)) - 20;
      set_in($urandom_range(0, 9) < 2, $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0,
             $urandom_range(0, 4) == 0, 32'($urandom_range(0, 270)),
             26'($urandom_range(0, 270)), o[15:0]);
      rst = (m_halt && $urandom_range(0, 3) == 0) || $urandom_range(0, 99) == 0;
      step();
    end
    rst = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter and next-PC stage directly upstream of the instruction memory bank in the single-cycle MIPS datapath.
- Drives the word address and the memread enable into instruction memory each cycle.
- Accepts redirect requests from control and ALU: branch, jump, jump-register.
- Tracks run, stall and halt state; halts cleanly when the PC leaves the loaded program space.

Parameters:
- MEM_DEPTH, 256: number of instruction words; valid PC range is 0..MEM_DEPTH-1.
- RESET_PC, 0: word address loaded on reset.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- stall  input  1  hold PC this cycle.
- branch_taken  input  1  branch condition met (beq resolved in the same cycle).
- branch_offset  input  16  signed word offset (instr[15:0]).
- jump  input  1  j-type redirect.
- jump_target  input  26  word target (instr[25:0]).
- jump_reg  input  1  jr redirect.
- reg_target  input  32  word target from register file.
- address  output  32  word address to instruction memory.
- memread  output  1  read enable to instruction memory.
- pc_plus1  output  32  address+1, for the link/branch datapath.
- fetch_valid  output  1  address/instruction pair is valid this cycle.
- halted  output  1  fetch stopped; sticky until rst.

Behaviour:
- PC is a word index: sequential next PC = PC+1; no byte addressing, no <<2.
- Reset (rst=1 at a clock edge):
  - State=BOOT, address=RESET_PC, memread=0, fetch_valid=0, halted=0.
  - rst has priority over every other input.
- States:
  - BOOT: one cycle after reset, memread=0, fetch_valid=0. Always goes to RUN; PC does not advance.
  - RUN: memread=1, fetch_valid=1; PC updates every edge. stall=1 -> STALL with PC held.
  - STALL: memread=1, fetch_valid=0, PC held. Returns to RUN at the first edge with stall=0. The PC advances on that same edge.
  - HALT: memread=0, fetch_valid=0, halted=1, address frozen. Exit only by rst.
- Next-PC priority, evaluated in RUN only: jump_reg > jump > branch_taken > sequential.
  - branch: pc_plus1 + sign_extend32(branch_offset).
  - jump: {pc_plus1[31:26], jump_target}.
  - jump_reg: reg_target.
- Arithmetic: all adds are 32-bit, modulo 2^32.
- Simultaneous events:
  - Multiple redirects in one cycle: resolved by the priority above; no error.
  - stall=1 together with a redirect: the redirect is dropped. Control must re-present it after the stall.
- Boundaries:
  - Computed next PC >= MEM_DEPTH (including wrap to a huge value): go to HALT. address keeps the last valid PC; halted=1 from the next cycle.
  - PC = MEM_DEPTH-1 with sequential flow: halts.
  - Branch offset of -1 (self loop): legal; PC stays constant with fetch_valid=1.
- pc_plus1 is combinational from address and is valid in every state.
- Latency: a redirect presented in cycle N is reflected on address in cycle N+1.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- When defined, the block adds two outputs:
  - fetch_count[31:0]: increments on each edge in RUN.
  - redirect_count[31:0]: increments when RUN takes a jump_reg, jump or taken-branch path.
  - Both counters clear on rst, saturate at all-ones, and freeze in HALT.
- When undefined, neither the ports nor the registers exist; all other behaviour is identical.

Decomposition:
- Shared package mips_fetch_pkg holds:
  - state enum: BOOT, RUN, STALL, HALT (2-bit encoding);
  - PC_W=32 and the next-PC select encoding (SEQ, BR, J, JR).
- One natural sub-module, next_pc_mux: combinational priority select plus adders. It returns next_pc and an out_of_range flag.
- The state register and PC register stay in the top module.

Test Plan:
- Reset release, no redirects: address sequence 0, 0 (BOOT, memread=0), 1, 2, 3; fetch_valid goes high in cycle 2.
- Branch: at PC=46, branch_taken=1, offset=0x0039 -> next address 104. Offset=0xFFFF at PC=10 -> address stays 10.
- Jump: at PC=56, jump=1, target=0x2C -> next address 44. jump and jump_reg both asserted with reg_target=7 -> next address 7.
- Stall: stall held 3 cycles at PC=20 together with jump=1 -> address stays 20 and fetch_valid=0 for 3 cycles; the jump is dropped; next address 21.
- Halt: sequential run to PC=255 -> halted=1, memread=0, address frozen at 255; the same happens for jump_reg to 0x100. rst mid-halt returns to BOOT at address 0.
- With FETCH_PERF_CNT_EN: 10 sequential fetches plus 2 redirects -> fetch_count=12, redirect_count=2. Both read 0 one cycle after rst.
